// File: rtl/dataram_port_arbiter_if.sv
// Request/response bundle between the pipeline MEM stage, the debug port
// and the data RAM; the arbiter takes the slave view.
interface dataram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              p_req;
    logic              p_we;
    logic [1:0]        p_size;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_ack;
    logic              p_err;
    logic              p_stall;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic              ram_en;
    logic              ram_we;
    logic [1:0]        ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Handshake: a requester raises req with stable we/size/addr/wdata and holds
    // them until its one-cycle ack; rdata/err are valid only in the ack cycle.
    // A req still high in the cycle after ack is taken as a new request.
    modport slave (
        input  p_req, p_we, p_size, p_addr, p_wdata,
        output p_rdata, p_ack, p_err, p_stall,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output ram_en, ram_we, ram_size, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output p_req, p_we, p_size, p_addr, p_wdata,
        input  p_rdata, p_ack, p_err, p_stall,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  ram_en, ram_we, ram_size, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dataram_port_arbiter.sv
// Shares the data RAM port between the pipeline MEM stage and the debug/loader
// port; pipeline has priority, debug is forced through after STARVE_MAX losses.
module dataram_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4,
    localparam int SW = $clog2(STARVE_MAX + 1),
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    dataram_port_arbiter_if.slave bus,
    output logic                 owner,
    output logic                 busy,
    output logic [1:0]           dbg_state,
    output logic [SW-1:0]        dbg_starve
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     starve_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              ram_en;
    logic              ram_we;
    logic [1:0]        ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              p_ack;
    logic              d_ack;
    logic              p_err;
    logic              d_err;

    logic              grant_d;
    logic              g_we;
    logic [1:0]        g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_misaligned;

    // Size 11 is handled as a word for the alignment check.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size[1] ? (lo != 2'b00) : (size[0] & lo[0]);
    endfunction

    always_comb begin
        grant_d      = 1'b0;
        g_we         = bus.p_we;
        g_size       = bus.p_size;
        g_addr       = bus.p_addr;
        g_wdata      = bus.p_wdata;
        grant_d      = bus.d_req & (~bus.p_req | (starve_cnt == SW'(STARVE_MAX)));
        if (grant_d) begin
            g_we    = bus.d_we;
            g_size  = bus.d_size;
            g_addr  = bus.d_addr;
            g_wdata = bus.d_wdata;
        end
        g_misaligned = misaligned(g_size, g_addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            owner      <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_size   <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            p_rdata    <= '0;
            d_rdata    <= '0;
            p_ack      <= 1'b0;
            d_ack      <= 1'b0;
            p_err      <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            p_ack <= 1'b0;
            d_ack <= 1'b0;
            p_err <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.p_req || bus.d_req) begin
                        owner     <= grant_d;
                        ram_we    <= g_we;
                        ram_size  <= g_size;
                        ram_addr  <= g_addr;
                        ram_wdata <= g_wdata;
                        if (grant_d) begin
                            starve_cnt <= '0;
                        end else if (bus.d_req && (starve_cnt != SW'(STARVE_MAX))) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                        // A misaligned access never touches the RAM.
                        if (g_misaligned) begin
                            state <= DONE;
                            if (grant_d) begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end else begin
                                p_ack <= 1'b1;
                                p_err <= 1'b1;
                            end
                        end else begin
                            state   <= ACCESS;
                            ram_en  <= 1'b1;
                            lat_cnt <= LW'(MEM_LAT - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        ram_en <= 1'b0;
                        state  <= DONE;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!ram_we) d_rdata <= bus.ram_rdata;
                        end else begin
                            p_ack <= 1'b1;
                            if (!ram_we) p_rdata <= bus.ram_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en    = ram_en;
    assign bus.ram_we    = ram_we;
    assign bus.ram_size  = ram_size;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.p_rdata   = p_rdata;
    assign bus.p_ack     = p_ack;
    assign bus.p_err     = p_err;
    assign bus.d_rdata   = d_rdata;
    assign bus.d_ack     = d_ack;
    assign bus.d_err     = d_err;
    // Feeds the hazard unit directly, so it must drop in the ack cycle itself.
    assign bus.p_stall   = bus.p_req & ~p_ack;

    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_starve = starve_cnt;

endmodule

// File: tb/tb_dataram_port_arbiter.sv
// Bench for dataram_port_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share a byte RAM model; sel picks which one is being exercised.
module tb_dataram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int EW = 51; // {ack_cycle[15:0], check_rdata, src, err, rdata[31:0]}

    logic clk;
    logic reset;
    logic sel;
    int   cyc;

    logic          p_req, p_we, d_req, d_we;
    logic [1:0]    p_size, d_size;
    logic [AW-1:0] p_addr, d_addr;
    logic [DW-1:0] p_wdata, d_wdata;

    logic [DW-1:0] p_rdata, d_rdata, ram_rdata, ram_wdata;
    logic          p_ack, d_ack, p_err, d_err, p_stall;
    logic          ram_en, ram_we;
    logic [1:0]    ram_size;
    logic [AW-1:0] ram_addr;
    logic          owner, busy;
    logic [1:0]    dbg_state;
    logic [2:0]    dbg_starve;
    logic          owner1, busy1, owner3, busy3;
    logic [1:0]    st1, st3;
    logic [2:0]    sv1, sv3;

    logic [7:0]    mem [0:511];
    logic [EW-1:0] exp_q[$];

    int n_vec, n_bad;
    int en_cycles, stall_cycles, p_ack_cnt, unstable;
    logic [AW-1:0] last_en_addr;

    dataram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    dataram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    dataram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .owner(owner1), .busy(busy1), .dbg_state(st1), .dbg_starve(sv1)
    );
    dataram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .reset(reset), .bus(if3.slave),
        .owner(owner3), .busy(busy3), .dbg_state(st3), .dbg_starve(sv3)
    );

    assign if1.p_req = p_req & ~sel;  assign if3.p_req = p_req & sel;
    assign if1.d_req = d_req & ~sel;  assign if3.d_req = d_req & sel;
    assign if1.p_we = p_we;           assign if3.p_we = p_we;
    assign if1.p_size = p_size;       assign if3.p_size = p_size;
    assign if1.p_addr = p_addr;       assign if3.p_addr = p_addr;
    assign if1.p_wdata = p_wdata;     assign if3.p_wdata = p_wdata;
    assign if1.d_we = d_we;           assign if3.d_we = d_we;
    assign if1.d_size = d_size;       assign if3.d_size = d_size;
    assign if1.d_addr = d_addr;       assign if3.d_addr = d_addr;
    assign if1.d_wdata = d_wdata;     assign if3.d_wdata = d_wdata;
    assign if1.ram_rdata = ram_rdata; assign if3.ram_rdata = ram_rdata;

    assign p_rdata    = sel ? if3.p_rdata   : if1.p_rdata;
    assign p_ack      = sel ? if3.p_ack     : if1.p_ack;
    assign p_err      = sel ? if3.p_err     : if1.p_err;
    assign p_stall    = sel ? if3.p_stall   : if1.p_stall;
    assign d_rdata    = sel ? if3.d_rdata   : if1.d_rdata;
    assign d_ack      = sel ? if3.d_ack     : if1.d_ack;
    assign d_err      = sel ? if3.d_err     : if1.d_err;
    assign ram_en     = sel ? if3.ram_en    : if1.ram_en;
    assign ram_we     = sel ? if3.ram_we    : if1.ram_we;
    assign ram_size   = sel ? if3.ram_size  : if1.ram_size;
    assign ram_addr   = sel ? if3.ram_addr  : if1.ram_addr;
    assign ram_wdata  = sel ? if3.ram_wdata : if1.ram_wdata;
    assign owner      = sel ? owner3 : owner1;
    assign busy       = sel ? busy3  : busy1;
    assign dbg_state  = sel ? st3    : st1;
    assign dbg_starve = sel ? sv3    : sv1;

    // Clock / reset / cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RAM model: little-endian bytes, read returns the containing word
    assign ram_rdata = {mem[{ram_addr[8:2], 2'd3}], mem[{ram_addr[8:2], 2'd2}],
                        mem[{ram_addr[8:2], 2'd1}], mem[{ram_addr[8:2], 2'd0}]};

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        {mem[59], mem[58], mem[57], mem[56]}   = 32'hDEADBEEF;
        {mem[3], mem[2], mem[1], mem[0]}       = 32'h11223344;
        {mem[7], mem[6], mem[5], mem[4]}       = 32'h55667788;
        {mem[227], mem[226], mem[225], mem[224]} = 32'hCAFEF00D;
        forever begin
            @(posedge clk);
            if (ram_en && ram_we) begin
                case (ram_size)
                    2'b00: mem[ram_addr] = ram_wdata[7:0];
                    2'b01: {mem[ram_addr + 9'd1], mem[ram_addr]} = ram_wdata[15:0];
                    default: {mem[ram_addr + 9'd3], mem[ram_addr + 9'd2],
                              mem[ram_addr + 9'd1], mem[ram_addr]} = ram_wdata;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        logic          prev_en;
        logic [43:0]   prev_f;
        prev_en = 1'b0;
        prev_f  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (ram_en) begin
                    en_cycles++;
                    last_en_addr = ram_addr;
                    if (prev_en && ({ram_we, ram_size, ram_addr, ram_wdata} !== prev_f)) unstable++;
                end
                prev_en = ram_en;
                prev_f  = {ram_we, ram_size, ram_addr, ram_wdata};
                if (p_stall) stall_cycles++;
                if (p_ack) p_ack_cnt++;
                if (p_ack && d_ack) begin
                    chk("single_ack", 64'({p_ack, d_ack}), 64'd1);
                end else if (p_ack || d_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_cycle", 64'(cyc[15:0]), 64'(e[50:35]));
                        chk("ack_src", 64'(d_ack), 64'(e[33]));
                        chk("ack_err", 64'(d_ack ? d_err : p_err), 64'(e[32]));
                        if (e[34]) chk("ack_rdata", 64'(d_ack ? d_rdata : p_rdata), 64'(e[31:0]));
                    end
                end
            end else begin
                prev_en = 1'b0;
            end
        end
    end

    // Driver tasks: called at #1 after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic src, input logic we, input logic [1:0] size,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic err, input logic [DW-1:0] rd, input int lat, input int gap);
        if (src) begin
            d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        end else begin
            p_req = 1'b1; p_we = we; p_size = size; p_addr = addr; p_wdata = wdata;
        end
        exp_q.push_back({16'(cyc + gap + (err ? 0 : lat)), (!we && !err), src, err, rd});
    endtask

    task automatic wait_ack(input logic src, input logic hold);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (src ? d_ack : p_ack) seen = 1'b1;
        end
        chk(src ? "d_ack_seen" : "p_ack_seen", 64'(seen), 64'd1);
        if (!hold) begin
            if (src) d_req = 1'b0; else p_req = 1'b0;
            step();
        end
    endtask

    initial begin
        int base_en, base_stall, base_pack, base, acks;
        int exp_st[6] = '{1, 2, 3, 4, 0, 1};
        n_vec = 0; n_bad = 0; en_cycles = 0; stall_cycles = 0; p_ack_cnt = 0; unstable = 0;
        last_en_addr = '0;
        sel = 1'b0; reset = 1'b0;
        p_req = 0; p_we = 0; p_size = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        repeat (3) step();

        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_acks", 64'({p_ack, d_ack, p_err, d_err}), 64'd0);
        chk("rst_rdata", 64'({p_rdata, d_rdata}), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_starve", 64'(dbg_starve), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        step();

        // Pipeline word read of addr 56, MEM_LAT=1
        base_en = en_cycles; base_stall = stall_cycles;
        issue(0, 0, 2'b10, 9'd56, 32'h0, 0, 32'hDEADBEEF, 1, 1);
        wait_ack(0, 0);
        chk("rd56_en_cycles", 64'(en_cycles - base_en), 64'd1);
        chk("rd56_ram_addr", 64'(last_en_addr), 64'd56);
        chk("rd56_stall_cycles", 64'(stall_cycles - base_stall), 64'd2);

        // Debug byte write 0xA5 to addr 44, then read the word back
        base_pack = p_ack_cnt;
        issue(1, 1, 2'b00, 9'd44, 32'h000000A5, 0, 32'h0, 1, 1);
        wait_ack(1, 0);
        chk("wr44_ram_byte", 64'(mem[44]), 64'hA5);
        chk("wr44_owner", 64'(owner), 64'd1);
        chk("wr44_no_p_ack", 64'(p_ack_cnt - base_pack), 64'd0);
        issue(1, 0, 2'b10, 9'd44, 32'h0, 0, 32'h000000A5, 1, 1);
        wait_ack(1, 0);

        // Misaligned pipeline word store to 58 and debug halfword read of 45
        base_en = en_cycles;
        issue(0, 1, 2'b10, 9'd58, 32'h12345678, 1, 32'h0, 1, 1);
        wait_ack(0, 0);
        issue(1, 0, 2'b01, 9'd45, 32'h0, 1, 32'h0, 1, 1);
        wait_ack(1, 0);
        chk("misalign_en_cycles", 64'(en_cycles - base_en), 64'd0);
        chk("misalign_ram_58", 64'({mem[59], mem[58]}), 64'hDEAD);

        // Both requesting continuously: grants P,P,P,P,D,P every 3 cycles
        p_req = 1; p_we = 0; p_size = 2'b10; p_addr = 9'd0;
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 9'd4;
        base = cyc;
        for (int i = 0; i < 6; i++)
            exp_q.push_back({16'(base + 2 + 3 * i), 1'b1, (i == 4), 1'b0,
                             (i == 4) ? 32'h55667788 : 32'h11223344});
        acks = 0;
        for (int i = 0; i < 40 && acks < 6; i++) begin
            step();
            if (p_ack || d_ack) begin
                chk("starve_cnt", 64'(dbg_starve), 64'(exp_st[acks]));
                chk("grant_owner", 64'(owner), 64'(acks == 4));
                acks++;
            end
        end
        chk("starve_acks", 64'(acks), 64'd6);
        p_req = 0; d_req = 0;
        repeat (2) step();

        // MEM_LAT=3: debug read of 224, then a back-to-back request
        sel = 1'b1;
        step();
        base_en = en_cycles;
        issue(1, 0, 2'b10, 9'd224, 32'h0, 0, 32'hCAFEF00D, 3, 1);
        wait_ack(1, 1);
        chk("lat3_en_cycles", 64'(en_cycles - base_en), 64'd3);
        chk("lat3_ram_addr", 64'(last_en_addr), 64'd224);
        step();
        chk("b2b_idle_state", 64'(dbg_state), 64'd0);
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        base_en = en_cycles;
        issue(1, 0, 2'b10, 9'd224, 32'h0, 0, 32'hCAFEF00D, 3, 1);
        wait_ack(1, 0);
        chk("b2b_en_cycles", 64'(en_cycles - base_en), 64'd3);

        // Reset during the second ACCESS cycle aborts without ack
        p_req = 1; p_we = 0; p_size = 2'b10; p_addr = 9'd224;
        step();
        step();
        chk("abort_in_access", 64'({dbg_state, ram_en}), 64'({2'd1, 1'b1}));
        reset = 1'b0; p_req = 1'b0;
        step();
        chk("abort_state", 64'(dbg_state), 64'd0);
        chk("abort_ram_en", 64'(ram_en), 64'd0);
        chk("abort_no_ack", 64'(p_ack), 64'd0);
        reset = 1'b1;
        repeat (4) step();
        issue(0, 0, 2'b10, 9'd224, 32'h0, 0, 32'hCAFEF00D, 3, 1);
        wait_ack(0, 0);
        repeat (2) step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("ram_fields_stable", 64'(unstable), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dataram_port_arbiter.md
Name: dataram_port_arbiter

Overview:
- Shares the single byte-addressed data RAM port between two requesters:
  - the pipeline MEM stage (loads/stores);
  - a debug/loader port used by benches and the bring-up monitor to read or patch memory while the core runs.
- Sits between the PPU MEM stage and the data RAM.
- Sequences multi-cycle RAM accesses, stalls the pipeline while it waits, and prevents debug starvation.

Parameters:
- ADDR_W, 9, byte-address width of the data RAM (512 bytes).
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles ram_en is held per access (≥1).
- STARVE_MAX, 4, consecutive debug losses before debug is forced to win.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low.
- p_req  input  1  pipeline access request, held until p_ack.
- p_we  input  1  pipeline write enable.
- p_size  input  2  00 byte, 01 halfword, 10 word (11 treated as word).
- p_addr  input  ADDR_W  pipeline byte address.
- p_wdata  input  DATA_W  pipeline store data.
- p_rdata  output  DATA_W  pipeline load data, valid with p_ack.
- p_ack  output  1  one-cycle completion pulse.
- p_err  output  1  misalignment flag, valid with p_ack.
- p_stall  output  1  combinational p_req & ~p_ack, drives pipeline hazard unit.
- d_req, d_we, d_size, d_addr, d_wdata  inputs  as pipeline  debug request bundle.
- d_rdata, d_ack, d_err  outputs  as pipeline  debug response bundle.
- ram_en  output  1  RAM access enable.
- ram_we  output  1  RAM write enable.
- ram_size  output  2  RAM access size.
- ram_addr  output  ADDR_W  RAM byte address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data, valid on the last ram_en cycle.
- owner  output  1  0 pipeline, 1 debug; current or last grant.
- busy  output  1  high in ACCESS or DONE.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE, starve_cnt=0, owner=0, lat_cnt=0.
  - All ack/err/ram_en/ram_we=0; rdata registers=0; ram_addr/ram_wdata/ram_size=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - Only one req high: that requester wins.
  - Both high: pipeline wins, unless starve_cnt==STARVE_MAX, then debug wins.
- IDLE, on the grant edge:
  - Latch winner's we/size/addr/wdata into RAM-side registers; set owner.
  - starve_cnt: +1 (saturating) if debug requested and lost; cleared when debug wins; unchanged otherwise.
- Alignment check on the grant edge:
  - word with addr[1:0]≠0, or halfword with addr[0]≠0 → IDLE→DONE directly, err=1.
  - ram_en is never asserted; no write occurs.
- Otherwise IDLE→ACCESS with lat_cnt=MEM_LAT-1.
- ACCESS:
  - ram_en=1 with latched fields stable for exactly MEM_LAT cycles.
  - lat_cnt decrements each edge.
  - At the edge where lat_cnt==0: capture ram_rdata into the owner's rdata register (reads only; writes leave rdata unchanged); →DONE.
- DONE:
  - Owner's ack=1 for exactly one cycle; err per check; then →IDLE.
  - The other requester's ack stays 0.
- Latency:
  - Aligned access: request seen in IDLE at edge T; ack high during cycle T+MEM_LAT+1.
  - Misaligned: ack during cycle T+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles; IDLE is always re-entered.
- Requester rules:
  - Hold req and request fields stable until ack.
  - Deasserting req mid-access does not abort; the access completes and ack still pulses.
  - A req still high in the cycle after ack is a new request.
- Write data is passed whole.
  - Byte lane selection is the RAM's job, using ram_size and ram_addr.
  - Read data is returned as the RAM provides it; no extension here.
- Reset low during ACCESS/DONE:
  - Abort at that edge; state=IDLE, no ack issued.
  - The RAM write may already have occurred; this is acceptable.
- p_stall is purely combinational:
  - high in the IDLE cycle of a pending pipeline request;
  - low in the p_ack cycle.
- busy=1 in ACCESS and DONE, 0 in IDLE.

Test Plan:
- Pipeline word read, MEM_LAT=1, RAM holds 0xDEADBEEF at addr 56 → ram_en high 1 cycle with ram_addr=56; p_ack 2 cycles after request; p_rdata=0xDEADBEEF; p_stall high 2 cycles.
- Debug byte write 0xA5 to addr 44 while pipeline idle → d_ack after MEM_LAT+1; RAM byte 44=0xA5; owner=1; p_ack never asserted.
- Both requesting continuously, STARVE_MAX=4 → grant sequence P,P,P,P,D,P…; starve_cnt 0→4 then cleared on the debug grant.
- Pipeline word store to addr 58 (misaligned) → p_ack and p_err 1 cycle after request; ram_en never asserted; RAM unchanged.
- MEM_LAT=3, debug read of addr 224 → ram_en high exactly 3 cycles with stable fields; d_ack cycle 4; second back-to-back request granted only after IDLE.
- reset driven low during ACCESS cycle 2 → next cycle state IDLE, ram_en=0, no ack; a fresh request completes normally afterwards.
